// File: rtl/io_request_arbiter_if.sv
// io_request_arbiter_if: requester side and I/O-module side of the shared
// processor I/O port. The arbiter uses the slave view; the other side uses master.
interface io_request_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    req_rd;
   logic [NUM_REQ-1:0]    req_wr;
   logic [10*NUM_REQ-1:0] req_addr;
   logic [32*NUM_REQ-1:0] req_data;
   logic [32*NUM_REQ-1:0] req_drs;
   logic [NUM_REQ-1:0]    ack;
   logic [NUM_REQ-1:0]    err;
   logic [31:0]           rd_data;
   logic                  io_in_req;
   logic                  io_new_out;
   logic [9:0]            io_adress;
   logic [31:0]           io_p_data;
   logic [31:0]           io_drs;
   logic [31:0]           io_e_data;
   logic                  io_in_ready;
   logic                  io_out_ready;
   logic                  busy;

   modport slave (
      input  req_rd, req_wr, req_addr, req_data, req_drs,
      input  io_e_data, io_in_ready, io_out_ready,
      output ack, err, rd_data, busy,
      output io_in_req, io_new_out, io_adress, io_p_data, io_drs
   );

   modport master (
      output req_rd, req_wr, req_addr, req_data, req_drs,
      output io_e_data, io_in_ready, io_out_ready,
      input  ack, err, rd_data, busy,
      input  io_in_req, io_new_out, io_adress, io_p_data, io_drs
   );
endinterface

// File: rtl/io_request_arbiter.sv
// io_request_arbiter: round-robin sharing of the processor I/O port.
// Optional macro IOARB_TIMEOUT_EN adds an ISSUE wait limit with err reporting.
module io_request_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                 clk,
   input logic                 rst,
   io_request_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num
      $error("io_request_arbiter: NUM_REQ must be 2..4");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_to
      $error("io_request_arbiter: TIMEOUT_CYCLES must be 1..65536");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RELEASE
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_ptr;
   logic [IW-1:0]     r_owner;
   logic              r_op_rd;
   logic [9:0]        r_addr;
   logic [31:0]       r_data;
   logic [31:0]       r_drs;
   logic [31:0]       r_rd_data;
   logic [NUM_REQ-1:0] r_ack;
   logic [NUM_REQ-1:0] r_err;
   logic              r_in_req;
   logic              r_new_out;
   logic              r_busy;
`ifdef IOARB_TIMEOUT_EN
   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]       r_cnt;
`endif

   logic [NUM_REQ-1:0] w_pend;
   logic              w_found;
   logic [IW-1:0]     w_grant;
   logic [IW-1:0]     w_next_ptr;
   logic              w_grd;
   logic [9:0]        w_gaddr;
   logic [31:0]       w_gdata;
   logic [31:0]       w_gdrs;
   logic              w_done;
   int                w_j;

   assign w_pend = bus.req_rd | bus.req_wr;

   // First pending requester at or after the pointer, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_j = int'(r_ptr) + k;
         if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_j == i && w_pend[i]) begin
               w_found = 1'b1;
               w_grant = IW'(i);
            end
         end
      end
   end

   // Request fields of the winning requester; read wins over write.
   always_comb begin
      w_grd   = 1'b0;
      w_gaddr = '0;
      w_gdata = '0;
      w_gdrs  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IW'(i) == w_grant) begin
            w_grd   = bus.req_rd[i];
            w_gaddr = bus.req_addr[10*i +: 10];
            w_gdata = bus.req_data[32*i +: 32];
            w_gdrs  = bus.req_drs[32*i +: 32];
         end
      end
   end

   assign w_next_ptr = (int'(w_grant) == NUM_REQ - 1) ?
                       '0 : w_grant + 1'b1;
   assign w_done     = r_op_rd ? bus.io_in_ready : bus.io_out_ready;

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_owner   <= '0;
         r_op_rd   <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_drs     <= '0;
         r_rd_data <= '0;
         r_ack     <= '0;
         r_err     <= '0;
         r_in_req  <= 1'b0;
         r_new_out <= 1'b0;
         r_busy    <= 1'b0;
`ifdef IOARB_TIMEOUT_EN
         r_cnt     <= '0;
`endif
      end else begin
         r_ack <= '0;
         r_err <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_owner   <= w_grant;
                  r_ptr     <= w_next_ptr;
                  r_op_rd   <= w_grd;
                  r_addr    <= w_gaddr;
                  r_data    <= w_gdata;
                  r_drs     <= w_gdrs;
                  r_in_req  <= w_grd;
                  r_new_out <= ~w_grd;
                  r_busy    <= 1'b1;
                  r_state   <= S_ISSUE;
`ifdef IOARB_TIMEOUT_EN
                  r_cnt     <= '0;
`endif
               end
            end
            S_ISSUE: begin
               if (w_done) begin
                  r_in_req       <= 1'b0;
                  r_new_out      <= 1'b0;
                  r_ack[r_owner] <= 1'b1;
                  if (r_op_rd) r_rd_data <= bus.io_e_data;
                  r_state        <= S_RELEASE;
               end
`ifdef IOARB_TIMEOUT_EN
               else if (r_cnt == LIMIT) begin
                  r_in_req       <= 1'b0;
                  r_new_out      <= 1'b0;
                  r_ack[r_owner] <= 1'b1;
                  r_err[r_owner] <= 1'b1;
                  if (r_op_rd) r_rd_data <= 32'hFFFF_FFFF;
                  r_state        <= S_RELEASE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
`endif
            end
            S_RELEASE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ack        = r_ack;
   assign bus.err        = r_err;
   assign bus.rd_data    = r_rd_data;
   assign bus.io_in_req  = r_in_req;
   assign bus.io_new_out = r_new_out;
   assign bus.io_adress  = r_addr;
   assign bus.io_p_data  = r_data;
   assign bus.io_drs     = r_drs;
   assign bus.busy       = r_busy;
endmodule

// File: tb/tb_io_request_arbiter.sv
// tb_io_request_arbiter: vector table, directed corner sequences and
// randomized transactions against a round-robin reference model.
module tb_io_request_arbiter;
   localparam int N  = 2;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   io_request_arbiter_if #(.NUM_REQ(N)) bus ();

   io_request_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      bit          rd;
      logic [9:0]  a;
      logic [31:0] d;
      logic [31:0] s;
      int          lat;
      logic [31:0] ed;
      logic [N-1:0] exp_ack;
      logic [31:0] exp_rdd;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_rd       = '0;
      bus.req_wr       = '0;
      bus.req_addr     = '0;
      bus.req_data     = '0;
      bus.req_drs      = '0;
      bus.io_e_data    = '0;
      bus.io_in_ready  = 1'b0;
      bus.io_out_ready = 1'b0;
   endtask

   task automatic set_req(input int i, input bit rd, input bit wr,
                          input logic [9:0] a, input logic [31:0] d,
                          input logic [31:0] s);
      bus.req_rd[i]            = rd;
      bus.req_wr[i]            = wr;
      bus.req_addr[10*i +: 10] = a;
      bus.req_data[32*i +: 32] = d;
      bus.req_drs[32*i +: 32]  = s;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      chk("reset_ctl", {bus.ack, bus.err, bus.rd_data, bus.io_in_req,
                        bus.io_new_out, bus.busy}, '0);
      chk("reset_bus", {bus.io_adress, bus.io_p_data}, '0);
      chk("reset_drs", bus.io_drs, '0);
      rst = 1'b0;
   endtask

   // One isolated transaction from a single requester, DUT idle on entry.
   task automatic run_vec(input vec_t v);
      logic [N-1:0] z;
      z = '0;
      set_req(v.idx, v.rd, !v.rd, v.a, v.d, v.s);
      tick();
      chk("v_strobe", {bus.io_in_req, bus.io_new_out}, {v.rd, !v.rd});
      chk("v_addr", bus.io_adress, v.a);
      chk("v_pdata", bus.io_p_data, v.d);
      chk("v_drs", bus.io_drs, v.s);
      chk("v_busy", bus.busy, 1);
      for (int c = 1; c < v.lat; c++) begin
         set_req(v.idx, v.rd, !v.rd, ~v.a, ~v.d, ~v.s);
         tick();
         chk("v_hold", {bus.io_in_req, bus.io_new_out, bus.ack},
             {v.rd, !v.rd, z});
         chk("v_stable", {bus.io_adress, bus.io_p_data}, {v.a, v.d});
      end
      bus.io_e_data = v.ed;
      if (v.rd) bus.io_in_ready = 1'b1;
      else      bus.io_out_ready = 1'b1;
      tick();
      chk("v_ack", bus.ack, v.exp_ack);
      chk("v_err", bus.err, 0);
      chk("v_rddata", bus.rd_data, v.exp_rdd);
      chk("v_release", {bus.io_in_req, bus.io_new_out, bus.busy}, 3'b001);
      idle_inputs();
      tick();
      chk("v_idle", {bus.ack, bus.busy, bus.io_in_req, bus.io_new_out}, 0);
   endtask

   initial begin
      logic [N-1:0] e;
      logic [N-1:0] pr;
      logic [N-1:0] pw;
      logic [9:0]   ra  [N];
      logic [31:0]  rdd [N];
      logic [31:0]  rds [N];
      logic [31:0]  ed;
      logic [31:0]  m_rd;
      int           m_ptr;
      int           g;
      int           lat;
      int           cnt;
      bit           op_rd;

      tbl[0] = '{0, 1'b1, 10'd32,  32'h0,         32'h0,      5,
                 32'h0000_00A5, 2'b01, 32'h0000_00A5};
      tbl[1] = '{1, 1'b0, 10'd128, 32'hDEAD_BEEF, 32'h1234,   3,
                 32'h5555_5555, 2'b10, 32'h0000_00A5};
      tbl[2] = '{1, 1'b1, 10'd64,  32'h0,         32'h0,      1,
                 32'h1234_5678, 2'b10, 32'h1234_5678};
      tbl[3] = '{0, 1'b0, 10'd96,  32'hCAFE_F00D, 32'hABCD,   2,
                 32'h0,         2'b01, 32'h1234_5678};

      do_reset();
      for (int t = 0; t < 4; t++) run_vec(tbl[t]);

      // Contention: both writers held, immediate ready, grants alternate.
      do_reset();
      set_req(0, 1'b0, 1'b1, 10'd1, 32'h11, 32'h0);
      set_req(1, 1'b0, 1'b1, 10'd2, 32'h22, 32'h0);
      for (int t = 0; t < 4; t++) begin
         tick();
         chk("cont_owner", bus.io_adress, 10'((t % 2) + 1));
         chk("cont_strobe", bus.io_new_out, 1);
         bus.io_out_ready = 1'b1;
         tick();
         e = '0;
         e[t % 2] = 1'b1;
         chk("cont_ack", bus.ack, e);
         chk("cont_rel", {bus.io_in_req, bus.io_new_out}, 0);
         bus.io_out_ready = 1'b0;
         tick();
         chk("cont_idle", bus.busy, 0);
      end
      idle_inputs();
      tick();

      // Async reset mid-ISSUE; pointer must restart at 0.
      set_req(0, 1'b1, 1'b0, 10'd5, 32'h0, 32'h0);
      set_req(1, 1'b1, 1'b0, 10'd6, 32'h0, 32'h0);
      tick();
      chk("ar_grant0", bus.io_adress, 10'd5);
      tick();
      #3 rst = 1'b1;
      #1;
      chk("ar_async", {bus.io_in_req, bus.busy}, 0);
      bus.io_in_ready = 1'b1;
      tick();
      chk("ar_noack", bus.ack, 0);
      bus.io_in_ready = 1'b0;
      #2 rst = 1'b0;
      tick();
      chk("ar_regrant", {bus.io_in_req, bus.io_adress}, {1'b1, 10'd5});
      bus.io_in_ready = 1'b1;
      bus.io_e_data   = 32'h0BAD_F00D;
      tick();
      chk("ar_ack", bus.ack, 2'b01);
      idle_inputs();
      tick();

      // Stray ready pulses: in IDLE, and write-ready during a read.
      bus.io_in_ready  = 1'b1;
      bus.io_out_ready = 1'b1;
      tick();
      chk("stray_idle", {bus.ack, bus.busy}, 0);
      idle_inputs();
      set_req(1, 1'b1, 1'b0, 10'd7, 32'h0, 32'h0);
      tick();
      bus.io_out_ready = 1'b1;
      tick();
      chk("stray_issue", {bus.ack, bus.io_in_req, bus.busy}, 4'b0011);
      bus.io_out_ready = 1'b0;
      bus.io_in_ready  = 1'b1;
      bus.io_e_data    = 32'h0000_0042;
      tick();
      chk("stray_ack", {bus.ack, bus.rd_data}, {2'b10, 32'h42});
      idle_inputs();
      tick();

      // Ready arriving in the last allowed cycle: completes without error.
      set_req(0, 1'b1, 1'b0, 10'd9, 32'h0, 32'h0);
      tick();
      for (int c = 1; c < TO; c++) tick();
      chk("edge_strobe", bus.io_in_req, 1);
      bus.io_in_ready = 1'b1;
      bus.io_e_data   = 32'h77;
      tick();
      chk("edge_ack", {bus.ack, bus.err, bus.rd_data}, {2'b01, 2'b00, 32'h77});
      idle_inputs();
      tick();

`ifdef IOARB_TIMEOUT_EN
      set_req(0, 1'b1, 1'b0, 10'd9, 32'h0, 32'h0);
      tick();
      cnt = 0;
      for (int k = 0; k < 40 && bus.io_in_req; k++) begin
         cnt++;
         tick();
      end
      chk("to_cycles", cnt, TO);
      chk("to_ack", {bus.ack, bus.err}, 4'b0101);
      chk("to_rddata", bus.rd_data, 32'hFFFF_FFFF);
      idle_inputs();
      tick();
`else
      set_req(0, 1'b1, 1'b0, 10'd9, 32'h0, 32'h0);
      tick();
      for (int k = 0; k < 40; k++) tick();
      chk("wait_forever", {bus.io_in_req, bus.ack, bus.err}, 5'b10000);
      bus.io_in_ready = 1'b1;
      bus.io_e_data   = 32'h99;
      tick();
      chk("wait_ack", {bus.ack, bus.rd_data}, {2'b01, 32'h99});
      idle_inputs();
      tick();
`endif

      // Randomized transactions against the round-robin model.
      do_reset();
      m_ptr = 0;
      m_rd  = 32'h0;
      for (int it = 0; it < 80; it++) begin
         pr = N'($urandom);
         pw = N'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            pr = '0;
            pw = '0;
         end
         for (int i = 0; i < N; i++) begin
            ra[i]  = 10'($urandom);
            rdd[i] = $urandom;
            rds[i] = $urandom;
            set_req(i, pr[i], pw[i], ra[i], rdd[i], rds[i]);
         end
         if ((pr | pw) == '0) begin
            bus.io_in_ready  = 1'($urandom);
            bus.io_out_ready = 1'($urandom);
            tick();
            chk("rnd_idle", {bus.ack, bus.busy, bus.io_in_req,
                             bus.io_new_out}, 0);
            idle_inputs();
            continue;
         end
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && (pr[(m_ptr + k) % N] || pw[(m_ptr + k) % N]))
               g = (m_ptr + k) % N;
         end
         op_rd = pr[g];
         tick();
         chk("rnd_strobe", {bus.io_in_req, bus.io_new_out}, {op_rd, !op_rd});
         chk("rnd_addr", bus.io_adress, ra[g]);
         chk("rnd_data", {bus.io_p_data, bus.io_drs}, {rdd[g], rds[g]});
         lat = $urandom_range(1, 4);
         for (int c = 1; c < lat; c++) begin
            bus.req_data = {N{$urandom}};
            bus.req_rd   = N'($urandom);
            if (op_rd) bus.io_out_ready = 1'($urandom);
            else       bus.io_in_ready  = 1'($urandom);
            tick();
            chk("rnd_wait", {bus.ack, bus.io_in_req, bus.io_new_out,
                             bus.io_p_data}, {2'b00, op_rd, !op_rd, rdd[g]});
            bus.io_in_ready  = 1'b0;
            bus.io_out_ready = 1'b0;
         end
         ed = $urandom;
         bus.io_e_data = ed;
         if (op_rd) bus.io_in_ready = 1'b1;
         else       bus.io_out_ready = 1'b1;
         tick();
         e = '0;
         e[g] = 1'b1;
         if (op_rd) m_rd = ed;
         m_ptr = (g + 1) % N;
         chk("rnd_ack", {bus.ack, bus.err}, {e, 2'b00});
         chk("rnd_rddata", bus.rd_data, m_rd);
         idle_inputs();
         tick();
         chk("rnd_done", {bus.busy, bus.io_in_req, bus.io_new_out}, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
